// File: rtl/sram_controller.sv
`timescale 1ns/1ps
// Purpose : bridges a 32-bit MEM-stage load/store port onto a 16-bit asynchronous SRAM as two half-accesses.
// Latency : ready is low for 1+2*WAIT_CYCLES cycles per access; a line-buffer hit takes 1 cycle; read_data is valid in DONE.
// Backpres: ready low freezes the pipeline, which holds the request inputs stable until ready returns high.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   wr_en, rd_en             store / load request (a store wins when both are high)
//   address, write_data      byte address (bits [18:2] used) and store data
//   read_data, ready         registered load result, pipeline stall (active low)
//   sram_addr, sram_we_n     half-word address {address[18:2], half} and active-low write strobe
//   sram_dq_out, sram_dq_oe  write data and its output enable
//   sram_dq_in               read data returned by the SRAM
//
// Build option: define SRAM_LINE_BUFFER_EN to add a one-entry read buffer keyed by address[18:2].
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        half;
    logic        last_cyc;
    logic [16:0] tag;

    // Byte-offset and upper address bits are not decoded by this SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    assign tag       = address[18:2];
    assign last_cyc  = (wait_q == LAST_WAIT);
    assign sram_addr = {tag, half};
    assign read_data = rdata_q;

`ifdef SRAM_LINE_BUFFER_EN
    logic        buf_vld_q, buf_vld_d;
    logic [16:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_dat_q, buf_dat_d;
    logic        buf_hit;

    assign buf_hit = buf_vld_q && (buf_tag_q == tag);
`endif

    always_comb begin
        state_d     = state_q;
        wait_d      = 4'd0;
        rdata_d     = rdata_q;
        ready       = 1'b1;
        half        = 1'b0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'h0000;
`ifdef SRAM_LINE_BUFFER_EN
        buf_vld_d   = buf_vld_q;
        buf_tag_d   = buf_tag_q;
        buf_dat_d   = buf_dat_q;
`endif

        unique case (state_q)
            IDLE: begin
                ready = ~(rd_en | wr_en);
                if (wr_en) begin
                    state_d = WR_LO;
                end else if (rd_en) begin
`ifdef SRAM_LINE_BUFFER_EN
                    if (buf_hit) begin
                        // Hit: skip the SRAM entirely, result is ready in DONE.
                        state_d = DONE;
                        rdata_d = buf_dat_q;
                    end else begin
                        state_d = RD_LO;
                    end
`else
                    state_d = RD_LO;
`endif
                end
            end
            RD_LO: begin
                ready = 1'b0;
                if (last_cyc) begin
                    // Sample on the last cycle so the SRAM has had the full wait to settle.
                    rdata_d[15:0] = sram_dq_in;
                    state_d       = RD_HI;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RD_HI: begin
                ready = 1'b0;
                half  = 1'b1;
                if (last_cyc) begin
                    rdata_d[31:16] = sram_dq_in;
                    state_d        = DONE;
`ifdef SRAM_LINE_BUFFER_EN
                    buf_vld_d = 1'b1;
                    buf_tag_d = tag;
                    buf_dat_d = {sram_dq_in, rdata_q[15:0]};
`endif
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WR_LO: begin
                ready       = 1'b0;
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = write_data[15:0];
                if (last_cyc) begin
                    state_d = WR_HI;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WR_HI: begin
                ready       = 1'b0;
                half        = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = write_data[31:16];
                if (last_cyc) begin
                    state_d = DONE;
`ifdef SRAM_LINE_BUFFER_EN
                    // Keep the buffered copy coherent with the SRAM.
                    if (buf_hit) begin
                        buf_dat_d = write_data;
                    end
`endif
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset forces IDLE at the next edge, so stall as IDLE would right now.
        if (rst) begin
            ready = ~(rd_en | wr_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            rdata_q   <= 32'h0000_0000;
`ifdef SRAM_LINE_BUFFER_EN
            buf_vld_q <= 1'b0;
            buf_tag_q <= 17'h0;
            buf_dat_q <= 32'h0000_0000;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
`ifdef SRAM_LINE_BUFFER_EN
            buf_vld_q <= buf_vld_d;
            buf_tag_q <= buf_tag_d;
            buf_dat_q <= buf_dat_d;
`endif
        end
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001: Parameter WAIT_CYCLES, default 2, SHALL give the number of clock cycles each 16-bit half-access is held on the SRAM bus; legal range is 1..15.
REQ-002: clk  input  1  rising-edge system clock; the only clock in the block.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004: wr_en  input  1  store request from the MEM stage.
REQ-005: rd_en  input  1  load request from the MEM stage.
REQ-006: address  input  32  byte address from the ALU result; only address[18:2] is used.
REQ-007: write_data  input  32  store data (forwarded Val_Rm).
REQ-008: read_data  output  32  load result, registered.
REQ-009: ready  output  1  when low, the pipeline SHALL be frozen; the MEM-stage inputs are held stable while ready is low.
REQ-010: sram_addr  output  18  SRAM half-word address, equal to {address[18:2], half}.
REQ-011: sram_we_n  output  1  active-low SRAM write strobe.
REQ-012: sram_dq_out  output  16  write data driven to the SRAM.
REQ-013: sram_dq_in  input  16  read data returned from the SRAM.
REQ-014: sram_dq_oe  output  1  high while the block drives the DQ bus.

Function
REQ-015: The FSM SHALL have the states IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE.
REQ-016: In IDLE, wr_en SHALL move the FSM to WR_LO; otherwise rd_en SHALL move it to RD_LO; with neither asserted the FSM SHALL stay in IDLE.
REQ-017: When wr_en and rd_en are both high, the write SHALL take priority.
REQ-018: Each of RD_LO, RD_HI, WR_LO and WR_HI SHALL last exactly WAIT_CYCLES cycles, timed by a 4-bit wait counter that is cleared on entry to each state.
REQ-019: State sequencing SHALL be LO to HI to DONE; DONE SHALL return to IDLE unconditionally after 1 cycle and SHALL NOT start a new access.
REQ-020: ready SHALL equal ~(rd_en|wr_en) in IDLE, SHALL be 0 in the LO and HI states, and SHALL be 1 in DONE.
REQ-021: As a result, an access holds ready low for 1+2*WAIT_CYCLES cycles (5 cycles at the default).
REQ-022: The low half SHALL use sram_addr LSB=0 and data bits [15:0]; the high half SHALL use LSB=1 and data bits [31:16].
REQ-023: During WR_LO and WR_HI, sram_we_n=0, sram_dq_oe=1 and sram_dq_out carries the selected half of write_data.
REQ-024: In all other states, sram_we_n=1, sram_dq_oe=0 and sram_dq_out=0.
REQ-025: sram_dq_in SHALL be captured into read_data[15:0] on the last cycle of RD_LO and into read_data[31:16] on the last cycle of RD_HI.
REQ-026: read_data SHALL be valid in DONE and SHALL hold its value until the next read capture.
REQ-027: Writes SHALL NOT modify read_data.
REQ-028: A request that deasserts while the FSM is busy is a protocol violation; the FSM SHALL still complete the full sequence.

Reset
REQ-029: When rst is sampled high, the FSM SHALL go to IDLE with the wait counter at 0, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, and any buffer entry invalidated.
REQ-030: Reset SHALL take effect mid-access in any state; a write interrupted by reset may leave the SRAM with only its low half written.
REQ-031: While rst is high, ready SHALL follow the IDLE rule in REQ-020.

Configuration
REQ-032: The macro SRAM_LINE_BUFFER_EN SHALL compile in a one-entry read buffer holding a valid bit, a tag equal to address[18:2], and 32-bit data.
REQ-033: With the buffer compiled in, a read in IDLE whose tag matches a valid entry SHALL go directly to DONE, holding ready low for 1 cycle and loading read_data from the buffer.
REQ-034: With the buffer compiled in, every completed read SHALL fill the buffer; a completed write to a matching tag SHALL update the buffer data, and a write to any other tag SHALL leave the buffer unchanged.
REQ-035: Without the macro, no buffer logic SHALL exist and every read SHALL take the full sequence.

Verification
REQ-036: Write 0xDEADBEEF to address 0x00000404 (W=2): ready low 5 cycles; sram_addr 0x202 then 0x203; dq_out 0xBEEF then 0xDEAD; each half held with sram_we_n low for 2 cycles.
REQ-037: Read of address 0x404 with the SRAM model returning 0xBEEF/0xDEAD: read_data=0xDEADBEEF and ready=1 in DONE, after 5 ready-low cycles.
REQ-038: rd_en and wr_en both high: the write sequence SHALL occur and read_data SHALL be unchanged.
REQ-039: Assert rst during WR_HI: the next cycle shows IDLE outputs (sram_we_n=1, sram_dq_oe=0, read_data=0), and a following read completes normally.
REQ-040: With SRAM_LINE_BUFFER_EN, two back-to-back reads of 0x404: the second holds ready low 1 cycle with no SRAM activity; a write of 0x12345678 to 0x404 followed by a read returns 0x12345678.
REQ-041: Sweep WAIT_CYCLES over 1 and 15: ready-low duration equals 1+2*WAIT_CYCLES cycles.
